// File: rtl/state_disc_mc_if.sv
// Bus bundle for the multi-channel state discriminator: per-channel captures and
// config in, tagged results and status out.
interface state_disc_mc_if #(
  parameter int unsigned NCH    = 8,
  parameter int unsigned IN_DW  = 32,
  parameter int unsigned OUT_DW = 18
);
  localparam int unsigned CW = $clog2(NCH);

  logic [NCH-1:0]          start_trigger;
  logic [NCH*2*IN_DW-1:0]  accumulated_data;
  logic [NCH*2*IN_DW-1:0]  norm_min;
  logic [NCH*2*OUT_DW-1:0] weight;
  logic [NCH*OUT_DW-1:0]   bias;
  logic                    idle;
  logic                    done_trigger;
  logic [CW-1:0]           done_chan;
  logic [OUT_DW-1:0]       inference_score;
  logic                    inference_state;
  logic [NCH-1:0]          overrun;

  modport master (
    output start_trigger, accumulated_data, norm_min, weight, bias,
    input  idle, done_trigger, done_chan, inference_score, inference_state, overrun
  );

  modport slave (
    input  start_trigger, accumulated_data, norm_min, weight, bias,
    output idle, done_trigger, done_chan, inference_score, inference_state, overrun
  );
endinterface

// File: rtl/state_disc_mc.sv
// Multi-channel I/Q state discriminator: per-channel capture buffers, round-robin
// arbiter, shared normalize -> weight -> threshold pipeline.
module state_disc_mc #(
  parameter int unsigned NCH    = 8,
  parameter int unsigned IN_DW  = 32,
  parameter int unsigned OUT_DW = 18,
  parameter int unsigned SHIFT  = 8
) (
  input  logic           clk,
  input  logic           rst,
  state_disc_mc_if.slave bus
);
  localparam int unsigned CW = $clog2(NCH);
  localparam int unsigned PW = 2 * OUT_DW;
  localparam int unsigned SW = 2 * OUT_DW + 1;

  logic signed [IN_DW-1:0]  acc_i [NCH];
  logic signed [IN_DW-1:0]  acc_q [NCH];
  logic signed [IN_DW-1:0]  min_i [NCH];
  logic signed [IN_DW-1:0]  min_q [NCH];
  logic signed [OUT_DW-1:0] wt_i  [NCH];
  logic signed [OUT_DW-1:0] wt_q  [NCH];
  logic signed [OUT_DW-1:0] bias_c[NCH];

  for (genvar c = 0; c < NCH; c++) begin : g_unpack
    assign acc_i[c]  = bus.accumulated_data[c*2*IN_DW +: IN_DW];
    assign acc_q[c]  = bus.accumulated_data[c*2*IN_DW+IN_DW +: IN_DW];
    assign min_i[c]  = bus.norm_min[c*2*IN_DW +: IN_DW];
    assign min_q[c]  = bus.norm_min[c*2*IN_DW+IN_DW +: IN_DW];
    assign wt_i[c]   = bus.weight[c*2*OUT_DW +: OUT_DW];
    assign wt_q[c]   = bus.weight[c*2*OUT_DW+OUT_DW +: OUT_DW];
    assign bias_c[c] = bus.bias[c*OUT_DW +: OUT_DW];
  end

  logic [NCH-1:0]           pend_q, pend_d, ovr_q, ovr_d;
  logic [CW-1:0]            last_q, last_d;
  logic signed [IN_DW-1:0]  buf_i_q [NCH];
  logic signed [IN_DW-1:0]  buf_i_d [NCH];
  logic signed [IN_DW-1:0]  buf_q_q [NCH];
  logic signed [IN_DW-1:0]  buf_q_d [NCH];
  logic                     s1_v_q, s1_v_d, s2_v_q, s2_v_d, done_q, done_d;
  logic [CW-1:0]            s1_ch_q, s1_ch_d, s2_ch_q, s2_ch_d, done_ch_q, done_ch_d;
  logic signed [OUT_DW-1:0] s1_i_q, s1_i_d, s1_q_q, s1_q_d;
  logic signed [PW-1:0]     s2_pi_q, s2_pi_d, s2_pq_q, s2_pq_d;
  logic signed [OUT_DW-1:0] score_q, score_d;
  logic                     state_q, state_d;

  logic                     gnt_v;
  logic [CW-1:0]            gnt_ch, idx_cw;
  logic signed [IN_DW:0]    diff_i, diff_q;
  logic signed [SW-1:0]     sum, tot;

  // Clamp when the bits above the OUT_DW sign bit are not a pure sign extension.
  function automatic logic signed [OUT_DW-1:0] sat_n(input logic signed [IN_DW:0] v);
    logic [IN_DW-OUT_DW+1:0] top;
    top = v[IN_DW:OUT_DW-1];
    if (&top || ~|top) return v[OUT_DW-1:0];
    else if (v[IN_DW]) return {1'b1, {(OUT_DW-1){1'b0}}};
    else               return {1'b0, {(OUT_DW-1){1'b1}}};
  endfunction

  function automatic logic signed [OUT_DW-1:0] sat_s(input logic signed [SW-1:0] v);
    logic [SW-OUT_DW:0] top;
    top = v[SW-1:OUT_DW-1];
    if (&top || ~|top) return v[OUT_DW-1:0];
    else if (v[SW-1])  return {1'b1, {(OUT_DW-1){1'b0}}};
    else               return {1'b0, {(OUT_DW-1){1'b1}}};
  endfunction

  always_comb begin
    gnt_v  = 1'b0;
    gnt_ch = '0;
    idx_cw = '0;
    for (int k = 1; k <= int'(NCH); k++) begin
      idx_cw = CW'((int'(last_q) + k) % int'(NCH));
      if (!gnt_v && pend_q[idx_cw]) begin
        gnt_v  = 1'b1;
        gnt_ch = idx_cw;
      end
    end
  end

  always_comb begin
    pend_d  = pend_q;
    last_d  = last_q;
    ovr_d   = '0;
    buf_i_d = buf_i_q;
    buf_q_d = buf_q_q;
    if (gnt_v) begin
      pend_d[gnt_ch] = 1'b0;
      last_d         = gnt_ch;
    end
    // A capture always wins over the grant clear; the granted copy already left via buf_*_q.
    for (int c = 0; c < int'(NCH); c++) begin
      if (bus.start_trigger[c]) begin
        ovr_d[c]   = pend_q[c] && !(gnt_v && gnt_ch == CW'(c));
        pend_d[c]  = 1'b1;
        buf_i_d[c] = acc_i[c];
        buf_q_d[c] = acc_q[c];
      end
    end
  end

  always_comb begin
    diff_i  = (IN_DW+1)'(buf_i_q[gnt_ch]) - (IN_DW+1)'(min_i[gnt_ch]);
    diff_q  = (IN_DW+1)'(buf_q_q[gnt_ch]) - (IN_DW+1)'(min_q[gnt_ch]);
    s1_v_d  = gnt_v;
    s1_ch_d = gnt_ch;
    s1_i_d  = sat_n(diff_i >>> SHIFT);
    s1_q_d  = sat_n(diff_q >>> SHIFT);

    s2_v_d  = s1_v_q;
    s2_ch_d = s1_ch_q;
    s2_pi_d = PW'(s1_i_q) * PW'(wt_i[s1_ch_q]);
    s2_pq_d = PW'(s1_q_q) * PW'(wt_q[s1_ch_q]);

    sum       = SW'(s2_pi_q) + SW'(s2_pq_q);
    tot       = (sum >>> (OUT_DW-1)) + SW'(bias_c[s2_ch_q]);
    done_d    = s2_v_q;
    done_ch_d = done_ch_q;
    score_d   = score_q;
    state_d   = state_q;
    if (s2_v_q) begin
      done_ch_d = s2_ch_q;
      score_d   = sat_s(tot);
      state_d   = !score_d[OUT_DW-1] && (score_d != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q    <= '0;
      ovr_q     <= '0;
      last_q    <= CW'(NCH - 1);
      for (int c = 0; c < int'(NCH); c++) begin
        buf_i_q[c] <= '0;
        buf_q_q[c] <= '0;
      end
      s1_v_q    <= 1'b0;
      s1_ch_q   <= '0;
      s1_i_q    <= '0;
      s1_q_q    <= '0;
      s2_v_q    <= 1'b0;
      s2_ch_q   <= '0;
      s2_pi_q   <= '0;
      s2_pq_q   <= '0;
      done_q    <= 1'b0;
      done_ch_q <= '0;
      score_q   <= '0;
      state_q   <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      ovr_q     <= ovr_d;
      last_q    <= last_d;
      buf_i_q   <= buf_i_d;
      buf_q_q   <= buf_q_d;
      s1_v_q    <= s1_v_d;
      s1_ch_q   <= s1_ch_d;
      s1_i_q    <= s1_i_d;
      s1_q_q    <= s1_q_d;
      s2_v_q    <= s2_v_d;
      s2_ch_q   <= s2_ch_d;
      s2_pi_q   <= s2_pi_d;
      s2_pq_q   <= s2_pq_d;
      done_q    <= done_d;
      done_ch_q <= done_ch_d;
      score_q   <= score_d;
      state_q   <= state_d;
    end
  end

  assign bus.idle            = ~|pend_q & ~s1_v_q & ~s2_v_q & ~done_q;
  assign bus.done_trigger    = done_q;
  assign bus.done_chan       = done_ch_q;
  assign bus.inference_score = score_q;
  assign bus.inference_state = state_q;
  assign bus.overrun         = ovr_q;
endmodule
